// File: rtl/hot_cold_game_n.sv
// Hot/cold guessing game core: a free-running hex counter is frozen into a hidden target,
// then keypad guesses are judged as correct, closer or farther than the previous guess.
module hot_cold_game_n #(
    parameter int DIGITS    = 2,
    parameter int TICK_DIV  = 50000000,
    parameter int MAX_TRIES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stop,
    input  logic                show,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    output logic [4*DIGITS-1:0] disp_value,
    output logic [2:0]          digit_cnt,
    output logic                correct,
    output logic                closer,
    output logic                farther,
    output logic                lost,
    output logic [3:0]          tries,
    output logic [2:0]          state
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        ROLL  = 3'd0,
        ENTRY = 3'd1,
        JUDGE = 3'd2,
        WON   = 3'd3,
        LOST  = 3'd4
    } state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   counter_reg, counter_next;
    logic [PW-1:0]  presc_reg, presc_next;
    logic [W-1:0]   target_reg, target_next;
    logic [W-1:0]   guess_reg, guess_next;
    logic [W-1:0]   prev_diff_reg, prev_diff_next;
    logic [2:0]     digit_cnt_reg, digit_cnt_next;
    logic [3:0]     tries_reg, tries_next;
    logic           have_prev_reg, have_prev_next;
    logic           correct_reg, correct_next;
    logic           closer_reg, closer_next;
    logic           farther_reg, farther_next;
    logic           lost_reg, lost_next;
    logic           stop_q_reg;

    logic           stop_rise;
    logic [W-1:0]   guess_shift;
    logic [W-1:0]   diff;

    assign stop_rise = stop & ~stop_q_reg;
    assign diff      = (guess_reg >= target_reg) ? (guess_reg - target_reg)
                                                 : (target_reg - guess_reg);

    // A single-digit guess has no upper digits to shift along.
    generate
        if (DIGITS == 1) begin : g_shift_one
            assign guess_shift = key_code;
        end else begin : g_shift_multi
            assign guess_shift = {guess_reg[W-5:0], key_code};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ROLL;
            counter_reg   <= '0;
            presc_reg     <= '0;
            target_reg    <= '0;
            guess_reg     <= '0;
            prev_diff_reg <= '0;
            digit_cnt_reg <= '0;
            tries_reg     <= '0;
            have_prev_reg <= 1'b0;
            correct_reg   <= 1'b0;
            closer_reg    <= 1'b0;
            farther_reg   <= 1'b0;
            lost_reg      <= 1'b0;
            stop_q_reg    <= 1'b1;
        end else begin
            state_reg     <= state_next;
            counter_reg   <= counter_next;
            presc_reg     <= presc_next;
            target_reg    <= target_next;
            guess_reg     <= guess_next;
            prev_diff_reg <= prev_diff_next;
            digit_cnt_reg <= digit_cnt_next;
            tries_reg     <= tries_next;
            have_prev_reg <= have_prev_next;
            correct_reg   <= correct_next;
            closer_reg    <= closer_next;
            farther_reg   <= farther_next;
            lost_reg      <= lost_next;
            stop_q_reg    <= stop;
        end
    end

    always_comb begin
        state_next     = state_reg;
        counter_next   = counter_reg;
        presc_next     = presc_reg;
        target_next    = target_reg;
        guess_next     = guess_reg;
        prev_diff_next = prev_diff_reg;
        digit_cnt_next = digit_cnt_reg;
        tries_next     = tries_reg;
        have_prev_next = have_prev_reg;
        correct_next   = correct_reg;
        closer_next    = closer_reg;
        farther_next   = farther_reg;
        lost_next      = lost_reg;

        unique case (state_reg)
            ROLL: begin
                if (presc_reg == PW'(TICK_DIV - 1)) begin
                    presc_next   = '0;
                    counter_next = counter_reg + W'(1);
                end else begin
                    presc_next = presc_reg + PW'(1);
                end
                // Capture the value on display now, not the post-tick value.
                if (stop_rise) begin
                    target_next = counter_reg;
                    state_next  = ENTRY;
                end
            end
            ENTRY: begin
                if (key_valid) begin
                    guess_next     = guess_shift;
                    digit_cnt_next = digit_cnt_reg + 3'd1;
                    if (digit_cnt_reg + 3'd1 == 3'(DIGITS)) begin
                        state_next = JUDGE;
                    end
                end
            end
            JUDGE: begin
                tries_next     = tries_reg + 4'd1;
                correct_next   = (diff == '0);
                closer_next    = have_prev_reg && (diff < prev_diff_reg) && (diff != '0);
                farther_next   = have_prev_reg && (diff > prev_diff_reg);
                prev_diff_next = diff;
                have_prev_next = 1'b1;
                guess_next     = '0;
                digit_cnt_next = '0;
                if (diff == '0) begin
                    state_next = WON;
                end else if (tries_reg + 4'd1 == 4'(MAX_TRIES)) begin
                    lost_next  = 1'b1;
                    state_next = LOST;
                end else begin
                    state_next = ENTRY;
                end
            end
            WON, LOST: begin
                state_next = state_reg;
            end
            default: begin
                state_next = ROLL;
            end
        endcase
    end

    always_comb begin
        unique case (state_reg)
            ROLL:        disp_value = counter_reg;
            ENTRY, JUDGE: disp_value = show ? target_reg : guess_reg;
            default:     disp_value = target_reg;
        endcase
    end

    assign digit_cnt = digit_cnt_reg;
    assign correct   = correct_reg;
    assign closer    = closer_reg;
    assign farther   = farther_reg;
    assign lost      = lost_reg;
    assign tries     = tries_reg;
    assign state     = state_reg;
endmodule

// File: doc/hot_cold_game_n.md
# hot_cold_game_n

Parametrised multi-digit hot/cold guessing game core. A free-running hex counter is frozen by the stop button to form a hidden target. The player then enters guesses through the debounced keypad. After each complete guess the block flags correct, closer or farther relative to the previous guess, and ends the round on a win or after a try limit. It sits between the keypad decoder/debounce stage and the seven-segment/LED output stage of the game top level.

## Interface
- DIGITS, 2, hex digits in target and guess (1..4); value width W = 4*DIGITS
- TICK_DIV, 50000000, clk cycles per counter increment (>=1)
- MAX_TRIES, 8, guesses allowed before loss (1..15)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stop  in  1  stop button level; rising edge freezes counter
- show  in  1  level; while high in ENTRY, display shows target
- key_valid  in  1  one-cycle pulse, key_code valid
- key_code  in  4  hex digit from keypad decoder
- disp_value  out  W  value for seven-segment drivers
- digit_cnt  out  3  digits entered in current guess
- correct  out  1  green LED
- closer  out  1  red LED
- farther  out  1  blue LED
- lost  out  1  try limit exhausted
- tries  out  4  completed guesses this round
- state  out  3  ROLL=0, ENTRY=1, JUDGE=2, WON=3, LOST=4

## Operation
- Reset: state ROLL; counter, prescaler, target, guess, prev_diff, digit_cnt, tries = 0; have_prev, correct, closer, farther, lost = 0; stop_q = 1, so a button held through reset never captures.
- stop_rise = stop & ~stop_q; stop_q <= stop every cycle.
- ROLL:
  - Prescaler counts 0..TICK_DIV-1. At TICK_DIV-1 it returns to 0 and the counter increments, wrapping 2^W-1 -> 0.
  - disp_value = counter.
  - On stop_rise: target <= counter (the value displayed that cycle, even if a tick coincides) and state -> ENTRY.
  - key_valid is ignored.
- ENTRY:
  - On key_valid: guess <= {guess[W-5:0], key_code} and digit_cnt++.
  - When the accepted key makes digit_cnt reach DIGITS: state -> JUDGE.
  - disp_value = show ? target : guess.
  - Further stop edges are ignored until rst.
- JUDGE (exactly one cycle; key_valid ignored):
  - diff = |guess - target|, W-bit unsigned magnitude.
  - tries++.
  - correct <= (diff==0).
  - closer <= have_prev & diff<prev_diff & diff!=0.
  - farther <= have_prev & diff>prev_diff.
  - Equal diff: both closer and farther cleared.
  - prev_diff <= diff; have_prev <= 1; guess and digit_cnt <= 0.
  - Next state: WON if diff==0; else LOST if tries+1==MAX_TRIES (lost <= 1); else ENTRY.
- WON/LOST:
  - Terminal until rst; disp_value = target.
  - Flags hold; key_valid and stop are ignored.
- A correct guess on the final allowed try goes to WON, not LOST.
- rst in any state restores reset values on the next edge.

## Timing
- All outputs are registered except disp_value (mux of registers).
- Final-digit key_valid at edge t: state=JUDGE after t. correct/closer/farther/tries/state update after edge t+1.
- Hint flags hold until the next JUDGE; they do not clear on new key entry.
- stop_rise is sampled 1 cycle after the stop level rises, and target captures at that edge.
- With TICK_DIV=1 the counter increments every cycle.
- A key_valid in the same cycle the state enters ENTRY (the capture edge) is ignored. Keys are accepted from the following cycle.

## Test plan
- TICK_DIV=4, DIGITS=1: hold stop low 64 cycles -> disp_value steps every 4 cycles, 0..F, wrapping F->0; raise stop -> target equals the disp_value of the rise-detect cycle, and the counter freezes.
- DIGITS=2, MAX_TRIES=8, target forced 0x5A via TICK_DIV=1 capture:
  - guess 0x10 -> no hint, tries=1.
  - guess 0x70 (diff 0x16) -> closer=1.
  - guess 0x00 (diff 0x5A) -> farther=1.
  - guess 0x00 again -> closer=farther=0.
  - guess 0x5A -> correct=1, state=WON.
- MAX_TRIES=2: two wrong guesses -> lost=1, state=LOST; later keys leave tries=2 and disp_value=target.
- show high during ENTRY -> disp_value=target; show low -> partial guess shown; show has no effect in ROLL.
- stop held high through rst release -> no capture until stop falls and rises again. rst asserted mid-guess (digit_cnt=1) -> all outputs return to reset values next cycle.
- key_valid on the JUDGE cycle and on the capture cycle -> ignored; digit_cnt unchanged.
